elevator_request_scheduler: RTL and testbench
=============================================

Name: elevator_request_scheduler

Overview:
- Upstream stage of the elevator controller. Latches car and hall call buttons into a pending-floor bitmap.
- Picks the next target floor using SCAN (keep going in the current direction, reverse only when nothing is pending ahead).
- Drives the controller's requested-floor input and tracks the controller's completion flag to retire each call.
- Holds a door dwell interval between services.

Parameters:
- NUM_FLOORS, 16, number of serviceable floors (2..16).
- FLOOR_W, 4, floor index width; must satisfy 2**FLOOR_W >= NUM_FLOORS.
- DWELL_CYCLES, 5, clock cycles to wait at a served floor before the next dispatch (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- call_req  in  NUM_FLOORS  one bit per floor; a 1 in any cycle registers a call for that floor (level or pulse).
- cur_floor  in  FLOOR_W  current floor reported by the controller.
- ctrl_complete  in  1  controller movement-complete flag (1 = stopped).
- hold  in  1  freezes dispatch (overweight or door alert from the controller); pending calls are still latched.
- req_floor  out  FLOOR_W  target floor presented to the controller.
- req_valid  out  1  high while req_floor is an active, unserved target.
- pending  out  NUM_FLOORS  latched call bitmap (drives button lamps).
- dir_up  out  1  SCAN direction preference (1 = up).
- served_pulse  out  1  one-cycle strobe when a target is retired.

Behaviour:
- Reset (asynchronous) values: pending=0, req_floor=0, req_valid=0, dir_up=1, served_pulse=0, FSM=IDLE, dwell counter=0, armed=0.
- Pending update, every cycle: pending <= (pending | call_req) & ~clear_mask.
  - clear_mask is one-hot for req_floor only in the cycle a service retires; otherwise 0.
  - A call for the retiring floor in that same cycle is absorbed (stays cleared); the car is already there.
- Target select (combinational, from registered pending and cur_floor):
  - dir_up=1: lowest pending floor >= cur_floor. If none, highest pending floor < cur_floor, and flip dir_up to 0.
  - dir_up=0: mirror of the above (highest pending floor <= cur_floor, else lowest above and flip to 1).
  - Indices >= NUM_FLOORS are ignored.
- FSM states: IDLE, DISPATCH, SERVE, DWELL.
  - IDLE: if pending!=0 and hold=0, go to DISPATCH next cycle.
  - DISPATCH (1 cycle): register req_floor from the select result, set req_valid=1, update dir_up if a reversal occurred, set armed=0. Go to SERVE.
  - SERVE: armed becomes 1 the first cycle ctrl_complete=0 is sampled.
    - Retire when armed=1 and ctrl_complete=1 and cur_floor==req_floor: clear the bit, served_pulse=1, req_valid=0, load the dwell counter with DWELL_CYCLES, go to DWELL.
    - No re-targeting in SERVE. New calls, including ones nearer in the travel direction, wait for the next DISPATCH.
  - DWELL: decrement the counter every cycle with hold=0; freeze it while hold=1. At 0, go to IDLE.
- Service latency: a call at an idle car reaches DISPATCH 1 cycle after pending sets; req_valid rises 2 cycles after call_req.
- hold=1 in IDLE blocks DISPATCH. hold=1 in SERVE keeps req_valid high and does not retire early.
- A call for cur_floor while in IDLE is still dispatched normally; the controller completes without moving, then the call retires.
- Reset in mid-operation drops every pending call and returns all outputs to their reset values immediately.
- served_pulse is a registered output, high for exactly 1 cycle.

Decomposition:
- Shared package elevator_pkg holds:
  - FLOOR_W and NUM_FLOORS defaults.
  - FSM state enum sched_state_t {IDLE, DISPATCH, SERVE, DWELL}.
  - DWELL_CYCLES default.
- One sub-module: scan_select. It is purely combinational: inputs pending, cur_floor, dir_up; outputs target, target_found, reverse. It is tested standalone.

Test Plan:
- Reset, then call_req[5] pulsed with cur_floor=2: req_valid rises 2 cycles later with req_floor=5 and dir_up=1. Model drives ctrl_complete 1→0→1 and cur_floor to 5: served_pulse for 1 cycle, pending[5]=0, then DWELL lasts 5 cycles.
- pending {3,7,1}, cur_floor=2, dir_up=1: serve order 3, 7, 1. dir_up flips to 0 in the DISPATCH that selects floor 1.
- Call floor 6 while in SERVE heading to 9 from floor 4: target stays 9. Floor 6 is served next with dir_up=0.
- hold=1 with pending[4] set in IDLE: req_valid stays 0. Releasing hold gives req_valid=1 two cycles later. hold during DWELL extends it by exactly the held cycle count.
- call_req[8] asserted in the same cycle floor 8 retires: pending[8]=0 afterwards, with no second dispatch to floor 8.
- Reset asserted in SERVE with pending {2,9}: all outputs and pending are cleared asynchronously, before the next clock edge.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request scheduler.
// Default geometry, dwell timing and the scheduler FSM states.
package elevator_pkg;

    localparam int NUM_FLOORS_DEF   = 16;
    localparam int FLOOR_W_DEF      = 4;
    localparam int DWELL_CYCLES_DEF = 5;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        SERVE,
        DWELL
    } sched_state_t;

endpackage

// File: rtl/elevator_request_scheduler_scan_select.sv
// SCAN target picker: nearest pending floor ahead in the travel
// direction, otherwise the nearest one behind (flagged as a reversal).
module scan_select
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  dir_up,
    output logic [FLOOR_W-1:0]    target,
    output logic                  target_found,
    output logic                  reverse
);

    logic [FLOOR_W-1:0] lo_ge, lo_gt, hi_le, hi_lt;
    logic               f_lo_ge, f_lo_gt, f_hi_le, f_hi_lt;

    // Descending scan keeps the lowest hit, ascending keeps the highest.
    always_comb begin
        lo_ge   = '0;
        lo_gt   = '0;
        hi_le   = '0;
        hi_lt   = '0;
        f_lo_ge = 1'b0;
        f_lo_gt = 1'b0;
        f_hi_le = 1'b0;
        f_hi_lt = 1'b0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && i >= int'(cur_floor)) begin
                lo_ge   = FLOOR_W'(i);
                f_lo_ge = 1'b1;
            end
            if (pending[i] && i > int'(cur_floor)) begin
                lo_gt   = FLOOR_W'(i);
                f_lo_gt = 1'b1;
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && i <= int'(cur_floor)) begin
                hi_le   = FLOOR_W'(i);
                f_hi_le = 1'b1;
            end
            if (pending[i] && i < int'(cur_floor)) begin
                hi_lt   = FLOOR_W'(i);
                f_hi_lt = 1'b1;
            end
        end
    end

    always_comb begin
        target       = '0;
        target_found = 1'b0;
        reverse      = 1'b0;
        if (dir_up) begin
            if (f_lo_ge) begin
                target       = lo_ge;
                target_found = 1'b1;
            end else if (f_hi_lt) begin
                target       = hi_lt;
                target_found = 1'b1;
                reverse      = 1'b1;
            end
        end else begin
            if (f_hi_le) begin
                target       = hi_le;
                target_found = 1'b1;
            end else if (f_lo_gt) begin
                target       = lo_gt;
                target_found = 1'b1;
                reverse      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Latches floor calls, dispatches SCAN-ordered targets to the car
// controller, retires them on completion and holds a door dwell.
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
    parameter int FLOOR_W      = FLOOR_W_DEF,
    parameter int DWELL_CYCLES = DWELL_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  ctrl_complete,
    input  logic                  hold,
    output logic [FLOOR_W-1:0]    req_floor,
    output logic                  req_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  served_pulse
);

    sched_state_t          state, state_next;
    logic [7:0]            dwell_cnt;
    logic                  armed;
    logic                  retire;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic [FLOOR_W-1:0]    sel_target;
    logic                  sel_found;
    logic                  sel_reverse;

    scan_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan_select (
        .pending      (pending),
        .cur_floor    (cur_floor),
        .dir_up       (dir_up),
        .target       (sel_target),
        .target_found (sel_found),
        .reverse      (sel_reverse)
    );

    // armed proves the car actually moved (or cycled) since dispatch
    assign retire = (state == SERVE) && armed && ctrl_complete
                    && (cur_floor == req_floor);

    always_comb begin
        clear_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            clear_mask[i] = retire && (req_floor == FLOOR_W'(i));
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (|pending && !hold) state_next = DISPATCH;
            DISPATCH: state_next = sel_found ? SERVE : IDLE;
            SERVE:    if (retire) state_next = DWELL;
            DWELL:    if (!hold && dwell_cnt <= 8'd1) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending      <= '0;
            req_floor    <= '0;
            req_valid    <= 1'b0;
            dir_up       <= 1'b1;
            served_pulse <= 1'b0;
            dwell_cnt    <= '0;
            armed        <= 1'b0;
        end else begin
            pending      <= (pending | call_req) & ~clear_mask;
            served_pulse <= retire;
            unique case (state)
                DISPATCH: begin
                    if (sel_found) begin
                        req_floor <= sel_target;
                        req_valid <= 1'b1;
                        armed     <= 1'b0;
                        if (sel_reverse) dir_up <= ~dir_up;
                    end
                end
                SERVE: begin
                    if (!ctrl_complete) armed <= 1'b1;
                    if (retire) begin
                        req_valid <= 1'b0;
                        dwell_cnt <= 8'(DWELL_CYCLES);
                    end
                end
                DWELL: begin
                    if (!hold && dwell_cnt != 8'd0) dwell_cnt <= dwell_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler with a car model and
// a queue of expected service targets.
module tb_elevator_request_scheduler;

    localparam int NF = 16;
    localparam int FW = 4;
    localparam int DW = 5;

    typedef struct packed {
        logic [FW-1:0] floor;
        logic          dir;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] call_req;
    logic [FW-1:0] cur_floor;
    logic          ctrl_complete;
    logic          hold;
    logic [FW-1:0] req_floor;
    logic          req_valid;
    logic [NF-1:0] pending;
    logic          dir_up;
    logic          served_pulse;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    elevator_request_scheduler #(
        .NUM_FLOORS   (NF),
        .FLOOR_W      (FW),
        .DWELL_CYCLES (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .call_req      (call_req),
        .cur_floor     (cur_floor),
        .ctrl_complete (ctrl_complete),
        .hold          (hold),
        .req_floor     (req_floor),
        .req_valid     (req_valid),
        .pending       (pending),
        .dir_up        (dir_up),
        .served_pulse  (served_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [NF-1:0] m);
        call_req = m;
        tick();
        call_req = '0;
    endtask

    task automatic wait_valid(input int exp_n, input string tag);
        int n;
        n = 0;
        while (!req_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(req_valid), 32'(1));
        chk({tag, "_latency"}, 32'(n), 32'(exp_n));
    endtask

    // Car model: leave, travel to the target, stop; extra is a call
    // presented in the same cycle the service retires.
    task automatic do_serve(input logic [NF-1:0] extra);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL sb_empty observed=0 expected=entry");
        end else begin
            e = exp_q.pop_front();
            chk("req_floor", 32'(req_floor), 32'(e.floor));
            chk("dir_up", 32'(dir_up), 32'(e.dir));
            ctrl_complete = 1'b0;
            tick();
            cur_floor = e.floor;
            tick();
            chk("serve_valid_held", 32'(req_valid), 32'(1));
            chk("serve_no_pulse", 32'(served_pulse), 32'(0));
            ctrl_complete = 1'b1;
            call_req = extra;
            tick();
            call_req = '0;
            chk("served_pulse", 32'(served_pulse), 32'(1));
            chk("pending_cleared", 32'(pending[e.floor]), 32'(0));
            chk("valid_dropped", 32'(req_valid), 32'(0));
            tick();
            chk("pulse_one_cycle", 32'(served_pulse), 32'(0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        call_req = '0;
        cur_floor = '0;
        ctrl_complete = 1'b1;
        hold = 1'b0;
        repeat (3) tick();
        chk("rst_pending", 32'(pending), 32'(0));
        chk("rst_req_floor", 32'(req_floor), 32'(0));
        chk("rst_req_valid", 32'(req_valid), 32'(0));
        chk("rst_dir_up", 32'(dir_up), 32'(1));
        chk("rst_served", 32'(served_pulse), 32'(0));
        reset = 1'b0;
        tick();

        // single call: latency, service, dwell length
        cur_floor = 4'd2;
        pulse(16'h0020);
        chk("t1_pending", 32'(pending), 32'h20);
        chk("t1_valid_c1", 32'(req_valid), 32'(0));
        tick();
        chk("t1_valid_c2", 32'(req_valid), 32'(0));
        tick();
        chk("t1_valid_c3", 32'(req_valid), 32'(1));
        exp_q.push_back('{floor: 4'd5, dir: 1'b1});
        do_serve('0);
        pulse(16'h0080);
        exp_q.push_back('{floor: 4'd7, dir: 1'b1});
        wait_valid(DW, "t1_dwell");
        do_serve('0);

        // SCAN order 3, 7, then reverse to 1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cur_floor = 4'd2;
        tick();
        pulse(16'h008A);
        exp_q.push_back('{floor: 4'd3, dir: 1'b1});
        exp_q.push_back('{floor: 4'd7, dir: 1'b1});
        exp_q.push_back('{floor: 4'd1, dir: 1'b0});
        wait_valid(2, "t2_a");
        do_serve('0);
        wait_valid(DW + 1, "t2_b");
        do_serve('0);
        wait_valid(DW + 1, "t2_c");
        do_serve('0);

        // no re-targeting while serving
        cur_floor = 4'd4;
        pulse(16'h0200);
        exp_q.push_back('{floor: 4'd9, dir: 1'b1});
        wait_valid(DW, "t3_a");
        pulse(16'h0040);
        tick();
        chk("t3_target_kept", 32'(req_floor), 32'(9));
        do_serve('0);
        exp_q.push_back('{floor: 4'd6, dir: 1'b0});
        wait_valid(DW + 1, "t3_b");
        do_serve('0);

        // hold in IDLE, SERVE and DWELL
        repeat (8) tick();
        hold = 1'b1;
        pulse(16'h0010);
        repeat (10) tick();
        chk("t4_held_valid", 32'(req_valid), 32'(0));
        chk("t4_held_pending", 32'(pending), 32'h10);
        exp_q.push_back('{floor: 4'd4, dir: 1'b0});
        hold = 1'b0;
        wait_valid(2, "t4_release");
        hold = 1'b1;
        repeat (3) tick();
        chk("t4_serve_hold", 32'(req_valid), 32'(1));
        hold = 1'b0;
        do_serve('0);
        pulse(16'h0004);
        exp_q.push_back('{floor: 4'd2, dir: 1'b0});
        hold = 1'b1;
        repeat (3) tick();
        hold = 1'b0;
        wait_valid(DW, "t4_dwell_hold");
        do_serve('0);

        // call for the retiring floor in the retire cycle is absorbed
        pulse(16'h0100);
        exp_q.push_back('{floor: 4'd8, dir: 1'b1});
        wait_valid(DW, "t5");
        do_serve(16'h0100);
        repeat (20) tick();
        chk("t5_no_redispatch", 32'(req_valid), 32'(0));
        chk("t5_pending", 32'(pending), 32'(0));

        // asynchronous reset mid-service
        pulse(16'h0204);
        wait_valid(2, "t6");
        chk("t6_target", 32'(req_floor), 32'(9));
        ctrl_complete = 1'b0;
        tick();
        chk("t6_pending_pre", 32'(pending), 32'h204);
        #2 reset = 1'b1;
        #1;
        chk("t6_pending", 32'(pending), 32'(0));
        chk("t6_valid", 32'(req_valid), 32'(0));
        chk("t6_req_floor", 32'(req_floor), 32'(0));
        chk("t6_dir_up", 32'(dir_up), 32'(1));
        chk("t6_served", 32'(served_pulse), 32'(0));
        ctrl_complete = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("t6_idle_after", 32'(req_valid), 32'(0));
        chk("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
